sync2_toggle_event_mux: RTL and testbench
=========================================

# sync2_toggle_event_mux

Multi-channel successor to the single-channel two-flop toggle-to-pulse synchroniser. It brings CHANNELS asynchronous toggle-encoded event lines into the `clk` domain through a configurable-depth synchroniser and converts each toggle edge into a one-cycle pulse. Events are accumulated per channel in saturating pending counters and drained through a single valid/ready event stream with round-robin arbitration. It sits at the receive side of clock-domain crossings where several producers signal events by toggling, and one consumer services them in order.

## Interface
- CHANNELS, 4, number of toggle inputs (1..16)
- SYNC_STAGES, 2, synchroniser flops per channel (>= 2)
- CNT_W, 4, pending-counter and `evt_cnt` width (>= 1)
- Local: CHAN_W = max(1, $clog2(CHANNELS))
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-low reset
- toggle  in  CHANNELS  asynchronous toggle-encoded events; each level change is one event
- pulse  out  CHANNELS  one-cycle pulse per detected toggle edge, = synchronised toggle XOR out_toggle
- out_toggle  out  CHANNELS  registered copy of the synchronised toggle
- evt_valid  out  1  event record available
- evt_ready  in  1  consumer accepts the record when high together with evt_valid
- evt_chan  out  CHAN_W  channel index of the record
- evt_cnt  out  CNT_W  events coalesced into the record (>= 1)
- ovf  out  CHANNELS  sticky per-channel overflow flags (see Configuration)

## Operation
- Reset (rst low, asynchronous): all synchroniser flops, out_toggle, pending counters, evt_valid, evt_chan, evt_cnt and ovf go to 0. The round-robin pointer resets so channel 0 has highest priority.
- Per channel i: a SYNC_STAGES-deep flop chain feeds s_toggle[i]. out_toggle[i] <= s_toggle[i]. pulse[i] = s_toggle[i] ^ out_toggle[i].
- Pending counter pend[i] increments by 1 on each clock edge where pulse[i] is high. It saturates at 2^CNT_W-1.
- The output register has two states:
  - EMPTY (evt_valid=0).
  - FULL (evt_valid=1).
- Load condition: the state is EMPTY, or it is FULL with evt_ready=1. At a load edge the arbiter selects the first channel with pend != 0, searching from the channel after the last granted one and wrapping modulo CHANNELS. For that channel:
  - evt_chan <= index.
  - evt_cnt <= pend.
  - evt_valid <= 1.
  - pend is cleared. If pulse is high on the granted channel in the same cycle, pend becomes 1 instead of 0; no event is lost.
  - The last-granted pointer updates to the granted channel.
- If no channel has pend != 0 at a load edge: evt_valid <= 0 and the pointer is unchanged.
- While evt_valid=1 and evt_ready=0, evt_chan and evt_cnt hold stable. Pending counters keep accumulating.
- A FULL state with evt_ready=1 back-to-back-loads the next record, so sustained throughput is one record per cycle.
- Multiple channels pulsing in the same cycle are all counted; only the arbitration order is serialised.
- evt_ready is ignored while evt_valid=0.

## Timing
- Suppose toggle[i] changes and is first sampled at edge k:
  - s_toggle[i] changes at edge k+SYNC_STAGES-1.
  - pulse[i] is high for exactly one cycle, from that edge to edge k+SYNC_STAGES.
  - out_toggle[i] follows at edge k+SYNC_STAGES.
  - pend[i] increments at edge k+SYNC_STAGES.
  - With the output EMPTY and no competition, evt_valid rises at edge k+SYNC_STAGES+1.
- Toggle changes closer together than one clk period, on the same channel, are not guaranteed to be detected. Producers keep toggle stable for at least 2 clk periods per change.
- pulse is combinational from flops and carries no glitch-free guarantee beyond that. All other outputs are registered.

## Configuration
- Macro SYNC2_TOGGLE_EVT_OVF_EN.
  - Defined: ovf[i] sets at the edge where pulse[i] is high while pend[i] is already 2^CNT_W-1, i.e. an event is dropped. It stays set until reset.
  - Undefined: the overflow logic is not built and ovf is tied to 0. Saturation behaviour of pend is identical in both builds.

## Test plan
- Reset/latency: CHANNELS=4, SYNC_STAGES=2, evt_ready=1. Toggle channel 2 once → pulse[2] high for exactly one cycle, then next cycle evt_valid=1, evt_chan=2, evt_cnt=1; evt_valid drops the following cycle. All outputs are 0 during and immediately after reset.
- Coalescing under backpressure: evt_ready=0, one record pending. Toggle channel 1 five times, 3 cycles apart. Raise evt_ready → next record is evt_chan=1, evt_cnt=5.
- Round-robin: toggle channels 0, 1 and 3 in the same cycle, with evt_ready=1 → records in order chan 0, 1, 3 on consecutive cycles, each with evt_cnt=1. Repeat with channel 0 last granted → order 1, 3, 0.
- Saturation/overflow: CNT_W=4, evt_ready=0. Apply 17 toggles on channel 0 → evt_cnt=15 on drain. With the macro, ovf[0]=1 from the 16th-event edge and it stays set after drain; without the macro, ovf stays 0.
- Simultaneous grant and pulse: channel 2 has pend=3 and is granted in the same cycle its pulse is high → record evt_cnt=3, and a second record evt_chan=2, evt_cnt=1 follows.
- Reset mid-operation: assert rst with evt_valid=1 and nonzero pend → evt_valid, pend, ovf and out_toggle are 0 asynchronously. After release, no stale record appears until a new toggle arrives.

Source files
------------

// File: rtl/sync2_toggle_event_mux.sv
// Multi-channel toggle-to-pulse synchroniser with saturating per-channel event
// counters drained through a round-robin valid/ready stream. Optional macro: SYNC2_TOGGLE_EVT_OVF_EN.
module sync2_toggle_event_mux #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4,
  localparam int unsigned CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] toggle,
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] out_toggle,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [CHAN_W-1:0]   evt_chan,
  output logic [CNT_W-1:0]    evt_cnt,
  output logic [CHANNELS-1:0] ovf
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CHAN_W-1:0] LAST_RST = CHAN_W'(CHANNELS - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t               state, state_nx;
  logic [CHANNELS-1:0]  sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0]  s_toggle;
  logic [CNT_W-1:0]     pend [CHANNELS];
  logic [CHANNELS-1:0]  pend_nz;
  logic [CHAN_W-1:0]    last, last_nx;
  logic [CHAN_W-1:0]    cand, grant_idx;
  logic                 grant_found, load, grant_take;
  logic [CHAN_W-1:0]    chan_nx;
  logic [CNT_W-1:0]     cnt_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      out_toggle <= '0;
    end else begin
      sync_q[0] <= toggle;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      out_toggle <= s_toggle;
    end
  end

  assign s_toggle = sync_q[SYNC_STAGES-1];
  assign pulse    = s_toggle ^ out_toggle;

  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) pend_nz[i] = (pend[i] != '0);
  end

  // Search starts one past the last grant and wraps, so every channel is visited once.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last;
    cand        = '0;
    for (int unsigned k = 1; k <= CHANNELS; k++) begin
      cand = CHAN_W'((32'(last) + k) % CHANNELS);
      if (!grant_found && pend_nz[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign load       = (state == EMPTY) || evt_ready;
  assign grant_take = load && grant_found;

  always_comb begin
    state_nx = state;
    chan_nx  = evt_chan;
    cnt_nx   = evt_cnt;
    last_nx  = last;
    if (load) begin
      if (grant_found) begin
        state_nx = FULL;
        chan_nx  = grant_idx;
        cnt_nx   = pend[grant_idx];
        last_nx  = grant_idx;
      end else begin
        state_nx = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      evt_chan <= '0;
      evt_cnt  <= '0;
      last     <= LAST_RST;
    end else begin
      state    <= state_nx;
      evt_chan <= chan_nx;
      evt_cnt  <= cnt_nx;
      last     <= last_nx;
    end
  end

  assign evt_valid = (state == FULL);

  // A pulse landing on the granted channel restarts its count at 1 rather than 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) pend[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (grant_take && (grant_idx == CHAN_W'(i))) begin
          pend[i] <= pulse[i] ? CNT_W'(1) : '0;
        end else if (pulse[i] && (pend[i] != CNT_MAX)) begin
          pend[i] <= pend[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef SYNC2_TOGGLE_EVT_OVF_EN
  // A saturated channel being granted this cycle loses nothing, so it does not flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (pulse[i] && (pend[i] == CNT_MAX) &&
            !(grant_take && (grant_idx == CHAN_W'(i)))) begin
          ovf[i] <= 1'b1;
        end
      end
    end
  end
`else
  assign ovf = '0;
`endif

endmodule

// File: tb/tb_sync2_toggle_event_mux.sv
// Directed bench for sync2_toggle_event_mux: expected records are queued at
// stimulus time and compared when the DUT hands them off.
module tb_sync2_toggle_event_mux;

  localparam int unsigned CHANNELS    = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_W       = 4;

`ifdef SYNC2_TOGGLE_EVT_OVF_EN
  localparam logic [3:0] OVF0 = 4'b0001;
`else
  localparam logic [3:0] OVF0 = 4'b0000;
`endif

  typedef struct {
    int unsigned chan;
    int unsigned cnt;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] toggle;
  logic [3:0] pulse;
  logic [3:0] out_toggle;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_chan;
  logic [3:0] evt_cnt;
  logic [3:0] ovf;

  int   checks = 0;
  int   errors = 0;
  rec_t q[$];

  always #5 clk = ~clk;

  sync2_toggle_event_mux #(
    .CHANNELS   (CHANNELS),
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .toggle    (toggle),
    .pulse     (pulse),
    .out_toggle(out_toggle),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_chan  (evt_chan),
    .evt_cnt   (evt_cnt),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int unsigned c, input int unsigned n);
    rec_t r;
    r.chan = c;
    r.cnt  = n;
    q.push_back(r);
  endtask

  // Handshakes are observed at the falling edge, inputs change 1 ns after the rising edge.
  task automatic tick();
    rec_t e;
    @(negedge clk);
    if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
      if (q.size() == 0) begin
        chk("sb_unexpected", 32'(evt_chan), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("sb_chan", 32'(evt_chan), e.chan);
        chk("sb_cnt", 32'(evt_cnt), e.cnt);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic flip(input int unsigned ch);
    toggle = toggle ^ (4'(1) << ch);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) tick();
    chk("drain_empty", 32'(q.size()), 0);
  endtask

  initial begin
    rst       = 1'b0;
    toggle    = '0;
    evt_ready = 1'b1;
    ticks(2);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_chan", 32'(evt_chan), 0);
    chk("rst_cnt", 32'(evt_cnt), 0);
    chk("rst_pulse", 32'(pulse), 0);
    chk("rst_out_toggle", 32'(out_toggle), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst = 1'b1;
    ticks(2);
    chk("post_rst_valid", 32'(evt_valid), 0);

    // Latency of a single toggle on channel 2
    flip(2);
    push(2, 1);
    tick();
    chk("t1_pulse_pre", 32'(pulse), 0);
    tick();
    chk("t1_pulse", 32'(pulse), 32'h4);
    chk("t1_valid_early", 32'(evt_valid), 0);
    tick();
    chk("t1_pulse_end", 32'(pulse), 0);
    chk("t1_out_toggle", 32'(out_toggle), 32'h4);
    chk("t1_valid_wait", 32'(evt_valid), 0);
    tick();
    chk("t1_valid", 32'(evt_valid), 1);
    chk("t1_chan", 32'(evt_chan), 2);
    chk("t1_cnt", 32'(evt_cnt), 1);
    tick();
    chk("t1_valid_drop", 32'(evt_valid), 0);
    chk("t1_drained", 32'(q.size()), 0);

    // Coalescing under backpressure
    evt_ready = 1'b0;
    flip(3);
    push(3, 1);
    ticks(4);
    chk("t2_hold_valid", 32'(evt_valid), 1);
    push(1, 5);
    for (int n = 0; n < 5; n++) begin
      flip(1);
      ticks(3);
    end
    chk("t2_hold_chan", 32'(evt_chan), 3);
    chk("t2_hold_cnt", 32'(evt_cnt), 1);
    evt_ready = 1'b1;
    drain(10);
    tick();
    chk("t2_idle", 32'(evt_valid), 0);

    // Round robin with channel 3 last granted, then channel 0 last granted
    flip(3);
    push(3, 1);
    drain(10);
    flip(0); flip(1); flip(3);
    push(0, 1); push(1, 1); push(3, 1);
    drain(12);
    flip(0);
    push(0, 1);
    drain(10);
    flip(0); flip(1); flip(3);
    push(1, 1); push(3, 1); push(0, 1);
    drain(12);
    tick();
    chk("t3_idle", 32'(evt_valid), 0);

    // Saturation and overflow on channel 0
    evt_ready = 1'b0;
    flip(3);
    push(3, 1);
    ticks(4);
    push(0, 15);
    for (int n = 1; n <= 17; n++) begin
      flip(0);
      ticks(3);
      if (n == 15) chk("t4_ovf_before", 32'(ovf), 0);
      if (n == 16) chk("t4_ovf_set", 32'(ovf), 32'(OVF0));
    end
    chk("t4_hold_cnt", 32'(evt_cnt), 1);
    evt_ready = 1'b1;
    drain(10);
    chk("t4_ovf_sticky", 32'(ovf), 32'(OVF0));
    tick();
    chk("t4_idle", 32'(evt_valid), 0);

    // Grant of channel 2 coinciding with its pulse
    evt_ready = 1'b0;
    flip(3);
    push(3, 1);
    ticks(4);
    for (int n = 0; n < 3; n++) begin
      flip(2);
      ticks(3);
    end
    flip(2);
    push(2, 3);
    push(2, 1);
    ticks(2);
    chk("t5_pulse", 32'(pulse), 32'h4);
    evt_ready = 1'b1;
    drain(10);
    tick();
    chk("t5_idle", 32'(evt_valid), 0);
    chk("t5_ovf", 32'(ovf), 32'(OVF0));

    // Asynchronous reset while a record is held and another is pending
    evt_ready = 1'b0;
    flip(1);
    ticks(4);
    flip(0);
    ticks(3);
    chk("t6_valid_before", 32'(evt_valid), 1);
    rst = 1'b0;
    #2;
    chk("t6_async_valid", 32'(evt_valid), 0);
    chk("t6_async_chan", 32'(evt_chan), 0);
    chk("t6_async_cnt", 32'(evt_cnt), 0);
    chk("t6_async_out_toggle", 32'(out_toggle), 0);
    chk("t6_async_ovf", 32'(ovf), 0);
    chk("t6_async_pulse", 32'(pulse), 0);
    q.delete();
    toggle = '0;
    ticks(2);
    rst = 1'b1;
    evt_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tick();
      chk("t6_no_stale", 32'(evt_valid), 0);
    end
    flip(2);
    push(2, 1);
    drain(10);
    tick();
    chk("t6_idle", 32'(evt_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
